// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;

    // Most-negative two's-complement value of width w (MSB set, rest clear).
    function automatic logic [63:0] sat_neg(int w);
        return 64'(1) << (w - 1);
    endfunction

    // Most-positive two's-complement value of width w (MSB clear, rest set).
    function automatic logic [63:0] sat_pos(int w);
        return (64'(1) << (w - 1)) - 64'(1);
    endfunction

endpackage

// File: rtl/sub_bit_cell.sv
// sub_bit_cell: combinational one-bit full subtractor (a - b - br_in).
module sub_bit_cell (
    input  logic a,
    input  logic b,
    input  logic br_in,
    output logic d,
    output logic br_out
);
    assign d      = a ^ b ^ br_in;
    assign br_out = (~a & b) | (~(a ^ b) & br_in);
endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial two's-complement subtractor, o_diff = i_a - i_b,
// one bit per clock, LSB first, with unsigned borrow and signed overflow.
// Build option SERIAL_SUB_SAT_EN: saturate o_diff on signed overflow.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_over
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] rs;      // lower result bits, filled from the MSB side
    logic             br;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;
    logic             d;
    logic             br_out;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] fin;
    logic             ovf;

    sub_bit_cell u_cell (
        .a      (a_sh[0]),
        .b      (b_sh[0]),
        .br_in  (br),
        .d      (d),
        .br_out (br_out)
    );

    // On the last RUN edge the fresh bit d is the result MSB.
    assign raw = {d, rs};
    assign ovf = (a_msb != b_msb) && (d != a_msb);

`ifdef SERIAL_SUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg(WIDTH));
    localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos(WIDTH));
    assign fin = ovf ? (a_msb ? SAT_NEG : SAT_POS) : raw;
`else
    assign fin = raw;
`endif

    // State register; reset aborts any run immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_nxt = state;
        o_busy    = 1'b0;
        o_valid   = 1'b0;
        case (state)
            IDLE: if (i_start) state_nxt = RUN;
            RUN: begin
                o_busy = 1'b1;
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                o_busy    = 1'b1;
                o_valid   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, serial subtract step and result registration.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            rs       <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            o_diff   <= '0;
            o_borrow <= 1'b0;
            o_over   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        a_sh  <= i_a;
                        b_sh  <= i_b;
                        a_msb <= i_a[WIDTH-1];
                        b_msb <= i_b[WIDTH-1];
                        rs    <= '0;
                        br    <= 1'b0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    rs   <= (WIDTH-1)'({d, rs} >> 1);
                    br   <= br_out;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        o_diff   <= fin;
                        o_borrow <= br_out;
                        o_over   <= ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: scoreboard bench for serial_sub (WIDTH = 4).
module tb_serial_sub;
    localparam int WIDTH = 4;
`ifdef SERIAL_SUB_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       busy;
    logic       valid;
    logic [3:0] diff;
    logic       borrow;
    logic       over;

    serial_sub #(.WIDTH(WIDTH)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_a      (a),
        .i_b      (b),
        .o_busy   (busy),
        .o_valid  (valid),
        .o_diff   (diff),
        .o_borrow (borrow),
        .o_over   (over)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] diff;
        logic       borrow;
        logic       over;
    } exp_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] dw;
        logic [3:0] ds;
        logic       bo;
        logic       ov;
    } vec_t;

    exp_t sb[$];
    vec_t vt[4];
    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    int   nvalid = 0;
    logic stream_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop expectation on each o_valid, check hold between pulses.
    exp_t       mon_e;
    logic [3:0] last_diff = '0;
    int         prev_valid_cyc = 0;
    logic       prev_in_stream = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            last_diff      = '0;
            prev_in_stream = 1'b0;
        end else if (valid) begin
            nvalid++;
            check("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("diff",   diff,   mon_e.diff);
                check("borrow", borrow, mon_e.borrow);
                check("over",   over,   mon_e.over);
            end
            if (stream_mode && prev_in_stream)
                check("gap", 32'(cyc - prev_valid_cyc), WIDTH + 2);
            prev_valid_cyc = cyc;
            prev_in_stream = stream_mode;
            last_diff      = diff;
        end else begin
            check("diff_hold", diff, last_diff);
        end
    end

    task automatic wait_idle();
        @(negedge clk);
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        check("idle_timeout", busy, 0);
    endtask

    function automatic exp_t mk_exp(input vec_t v);
        exp_t e;
        e.diff   = SAT ? v.ds : v.dw;
        e.borrow = v.bo;
        e.over   = v.ov;
        return e;
    endfunction

    task automatic run_vec(input logic [3:0] va, vb, dw, ds, input logic bo, ov);
        vec_t v;
        int   nbusy;
        int   vidx;
        v = '{a: va, b: vb, dw: dw, ds: ds, bo: bo, ov: ov};
        wait_idle();
        start = 1'b1;
        a = va;
        b = vb;
        sb.push_back(mk_exp(v));
        @(negedge clk);
        start = 1'b0;
        a = ~va;
        b = 4'($urandom);
        nbusy = 0;
        vidx  = 0;
        for (int i = 1; i <= 20 && busy; i++) begin
            nbusy++;
            if (valid) vidx = i;
            if (i == 2) begin a = 4'($urandom); b = ~vb; end
            @(negedge clk);
        end
        check("busy_cycles", nbusy, WIDTH + 1);
        check("valid_cycle", vidx, WIDTH + 1);
    endtask

    initial begin
        int nv0;
        int idx;
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int nv0;
        int idx;
        vt[0] = '{a: 4'b0111, b: 4'b0011, dw: 4'b0100, ds: 4'b0100, bo: 1'b0, ov: 1'b0};
        vt[1] = '{a: 4'b1000, b: 4'b0001, dw: 4'b0111, ds: 4'b1000, bo: 1'b0, ov: 1'b1};
        vt[2] = '{a: 4'b0101, b: 4'b1011, dw: 4'b1010, ds: 4'b0111, bo: 1'b1, ov: 1'b1};
        vt[3] = '{a: 4'b0000, b: 4'b0001, dw: 4'b1111, ds: 4'b1111, bo: 1'b1, ov: 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy",   busy,   0);
        check("rst_valid",  valid,  0);
        check("rst_diff",   diff,   0);
        check("rst_borrow", borrow, 0);
        check("rst_over",   over,   0);
        #1 rst_n = 1'b1;

        // 3 - 7 leaves nonzero outputs so the abort below is visible
        run_vec(4'b0011, 4'b0111, 4'b1100, 4'b1100, 1'b1, 1'b0);

        // Reset mid-run aborts at once
        wait_idle();
        start = 1'b1;
        a = 4'b0111;
        b = 4'b0011;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy",   busy,   0);
        check("abort_valid",  valid,  0);
        check("abort_diff",   diff,   0);
        check("abort_borrow", borrow, 0);
        check("abort_over",   over,   0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        nv0 = nvalid;
        repeat (10) @(negedge clk);
        check("no_valid_after_abort", nvalid - nv0, 0);
        check("idle_after_abort", busy, 0);

        // Directed vectors
        run_vec(4'b0111, 4'b0011, 4'b0100, 4'b0100, 1'b0, 1'b0);
        run_vec(4'b0011, 4'b0111, 4'b1100, 4'b1100, 1'b1, 1'b0);
        run_vec(4'b1000, 4'b0001, 4'b0111, 4'b1000, 1'b0, 1'b1);
        run_vec(4'b0111, 4'b1111, 4'b1000, 4'b0111, 1'b1, 1'b1);
        run_vec(4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        run_vec(4'b0000, 4'b0001, 4'b1111, 4'b1111, 1'b1, 1'b0);
        run_vec(4'b1000, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        run_vec(4'b1111, 4'b1000, 4'b0111, 4'b0111, 1'b0, 1'b0);
        run_vec(4'b1000, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1);
        run_vec(4'b0101, 4'b1011, 4'b1010, 4'b0111, 1'b1, 1'b1);

        // Start held high every cycle, junk operands while busy
        wait_idle();
        stream_mode = 1'b1;
        idx = 0;
        nv0 = nvalid;
        for (int g = 0; g < 100 && idx < 4; g++) begin
            start = 1'b1;
            if (!busy) begin
                a = vt[idx].a;
                b = vt[idx].b;
                sb.push_back(mk_exp(vt[idx]));
                idx++;
            end else begin
                a = 4'($urandom);
                b = 4'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("stream_accepted", idx, 4);
        for (int g = 0; g < 40 && sb.size() != 0; g++) @(negedge clk);
        check("stream_drain", sb.size(), 0);
        check("stream_valids", nvalid - nv0, 4);
        stream_mode = 1'b0;

        repeat (4) @(negedge clk);
        check("sb_empty_end", sb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
